// File: rtl/accel_neuron_engine.sv
// Neuron command engine: buffers CPU bus words in a FIFO, parses header + (x, w) pairs,
// accumulates the Q-format dot product and returns a rounded, saturated, optionally ReLU'd result.
module accel_neuron_engine #(
    parameter int FIFO_DEPTH = 8,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_W      = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        accel_en,
    input  logic        bus_wr,
    input  logic [15:0] bus_data_in,
    output logic [15:0] bus_data_out,
    output logic        accel_done,
    output logic        busy,
    output logic        overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_W,
        S_MAC,
        S_FINISH
    } state_t;

    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a + RND;
        return s >>> FRAC_BITS;
    endfunction

    function automatic logic [15:0] sat_relu(input logic signed [ACC_W-1:0] r, input logic relu);
        logic [15:0] v;
        if (r > SAT_MAX)      v = 16'h7FFF;
        else if (r < SAT_MIN) v = 16'h8000;
        else                  v = r[15:0];
        if (relu && r[ACC_W-1]) v = 16'h0000;
        return v;
    endfunction

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          fifo_empty, fifo_full, push, pop;
    logic [15:0]   fifo_head;

    state_t                  state_q, state_d;
    logic                    relu_q, relu_d;
    logic [7:0]              cnt_q, cnt_d;
    logic signed [15:0]      x_q, x_d;
    logic signed [31:0]      prod_q, prod_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]             dout_q, dout_d;
    logic                    done_q, done_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_head  = mem_q[rd_ptr_q];
    // A full FIFO still accepts a word when the engine frees a slot in the same cycle.
    assign push       = bus_wr && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus_data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (bus_wr && !push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            relu_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            relu_q  <= relu_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        x_q    <= x_d;
        prod_q <= prod_d;
    end

    always_comb begin
        state_d = state_q;
        relu_d  = relu_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        if (accel_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        relu_d  = fifo_head[15];
                        cnt_d   = fifo_head[7:0];
                        acc_d   = '0;
                        state_d = (fifo_head[7:0] == 8'd0) ? S_FINISH : S_LOAD_X;
                    end
                end
                S_LOAD_X: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        x_d     = fifo_head;
                        state_d = S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        prod_d  = 32'(x_q) * 32'($signed(fifo_head));
                        state_d = S_MAC;
                    end
                end
                S_MAC: begin
                    acc_d   = acc_q + ACC_W'(prod_q);
                    cnt_d   = cnt_q - 8'd1;
                    state_d = (cnt_q == 8'd1) ? S_FINISH : S_LOAD_X;
                end
                S_FINISH: begin
                    dout_d  = sat_relu(round_shift(acc_q), relu_q);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus_data_out = dout_q;
    assign accel_done   = done_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_accel_neuron_engine.sv
// Self-checking bench for accel_neuron_engine: directed cases plus randomized commands
// compared against a plain-arithmetic dot-product model.
module tb_accel_neuron_engine;
    localparam int FRAC_BITS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        accel_en = 1'b0;
    logic        bus_wr = 1'b0;
    logic [15:0] bus_data_in = 16'h0000;
    logic [15:0] bus_data_out;
    logic        accel_done;
    logic        busy;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] cx [256];
    logic [15:0] cw [256];

    always #5 clk = ~clk;

    accel_neuron_engine #(
        .FIFO_DEPTH(8),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (40)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .accel_en    (accel_en),
        .bus_wr      (bus_wr),
        .bus_data_in (bus_data_in),
        .bus_data_out(bus_data_out),
        .accel_done  (accel_done),
        .busy        (busy),
        .overflow    (overflow)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Dot product of the stored pairs, rounded half up, saturated to 16 bits, then ReLU.
    function automatic logic [15:0] model(input int n, input bit relu);
        longint s;
        longint r;
        s = 0;
        for (int i = 0; i < n; i++)
            s += longint'($signed(cx[i])) * longint'($signed(cw[i]));
        r = (s + (longint'(1) << (FRAC_BITS - 1))) >>> FRAC_BITS;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r[15:0];
    endfunction

    task automatic write_word(input logic [15:0] w);
        bus_wr      = 1'b1;
        bus_data_in = w;
        @(negedge clk);
        bus_wr      = 1'b0;
    endtask

    task automatic send_cmd(input logic [15:0] hdr, input bit rnd);
        int n;
        n = int'(hdr[7:0]);
        if (rnd) accel_en = 1'($urandom_range(0, 1));
        write_word(hdr);
        for (int i = 0; i < 2 * n; i++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    accel_en = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
            write_word((i % 2 == 0) ? cx[i / 2] : cw[i / 2]);
        end
        accel_en = 1'b1;
    endtask

    task automatic wait_done(input string tag, input logic [15:0] exp, output int cyc);
        cyc = 0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (accel_done) break;
        end
        chk_eq({tag, " done"}, 32'(accel_done), 32'd1);
        if (accel_done) chk_eq(tag, 32'(bus_data_out), 32'(exp));
    endtask

    task automatic run_cmd(input string tag, input logic [15:0] hdr, input logic [15:0] exp);
        int cyc;
        send_cmd(hdr, 1'b0);
        wait_done(tag, exp, cyc);
        @(negedge clk);
        chk_eq({tag, " pulse"}, 32'(accel_done), 32'd0);
        chk_eq({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [15:0] rnd_val();
        logic [15:0] v;
        case ($urandom_range(0, 3))
            0: v = 16'($urandom);
            1: v = 16'($urandom_range(0, 16'h03FF));
            2: v = 16'h0000 - 16'($urandom_range(0, 16'h03FF));
            default: begin
                case ($urandom_range(0, 3))
                    0: v = 16'h7FFF;
                    1: v = 16'h8000;
                    2: v = 16'h0001;
                    default: v = 16'hFFFF;
                endcase
            end
        endcase
        return v;
    endfunction

    initial begin
        int cyc;
        int n;
        int dones;
        bit relu;
        logic [15:0] hdr;
        logic [15:0] exp;

        repeat (2) @(negedge clk);
        chk_eq("rst dout", 32'(bus_data_out), 32'h0);
        chk_eq("rst done", 32'(accel_done), 32'h0);
        chk_eq("rst busy", 32'(busy), 32'h0);
        chk_eq("rst ovf", 32'(overflow), 32'h0);
        rst_n = 1'b1;
        accel_en = 1'b1;
        @(negedge clk);

        cx[0] = 16'h0100; cw[0] = 16'h0200; cx[1] = 16'h0080; cw[1] = 16'h0100;
        run_cmd("dot2", 16'h0002, 16'h0280);

        cx[0] = 16'h7FFF; cw[0] = 16'h7FFF;
        run_cmd("sat_pos", 16'h0001, 16'h7FFF);
        cx[0] = 16'h8000; cw[0] = 16'h7FFF;
        run_cmd("sat_neg", 16'h0001, 16'h8000);
        cx[0] = 16'hFF00; cw[0] = 16'h0100;
        run_cmd("relu_on", 16'h8001, 16'h0000);
        run_cmd("relu_off", 16'h0001, 16'hFF00);
        repeat (3) @(negedge clk);
        chk_eq("hold", 32'(bus_data_out), 32'hFF00);

        // Pre-buffered commands released with accel_en to measure latency.
        accel_en = 1'b0;
        write_word(16'h0000);
        accel_en = 1'b1;
        wait_done("n0", 16'h0000, cyc);
        chk_eq("n0 latency", 32'(cyc), 32'd2);
        @(negedge clk);
        chk_eq("n0 idle", 32'(busy), 32'd0);

        accel_en = 1'b0;
        cx[0] = 16'h0100; cw[0] = 16'h0100;
        write_word(16'h0001); write_word(cx[0]); write_word(cw[0]);
        accel_en = 1'b1;
        wait_done("n1", model(1, 1'b0), cyc);
        chk_eq("n1 latency", 32'(cyc), 32'd5);

        // Nine writes into a stalled 8-entry FIFO: the last one is dropped.
        @(negedge clk);
        accel_en = 1'b0;
        cx[0] = 16'h0100; cw[0] = 16'h0100;
        cx[1] = 16'h0200; cw[1] = 16'hFF00;
        cx[2] = 16'h0300; cw[2] = 16'h0080;
        write_word(16'h0003);
        for (int i = 0; i < 3; i++) begin
            write_word(cx[i]);
            write_word(cw[i]);
        end
        write_word(16'h0000);
        chk_eq("pre ovf", 32'(overflow), 32'd0);
        write_word(16'h1234);
        chk_eq("ovf set", 32'(overflow), 32'd1);
        chk_eq("ovf busy", 32'(busy), 32'd1);
        accel_en = 1'b1;
        wait_done("ovf cmd1", model(3, 1'b0), cyc);
        wait_done("ovf cmd2", 16'h0000, cyc);
        @(negedge clk);
        chk_eq("ovf drained", 32'(busy), 32'd0);
        chk_eq("ovf sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a two-pair command.
        write_word(16'h0002); write_word(16'h0100); write_word(16'h0200);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_eq("mid rst dout", 32'(bus_data_out), 32'h0);
        chk_eq("mid rst done", 32'(accel_done), 32'h0);
        chk_eq("mid rst busy", 32'(busy), 32'h0);
        chk_eq("mid rst ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (accel_done) dones++;
        end
        chk_eq("no stray done", 32'(dones), 32'd0);
        chk_eq("post rst busy", 32'(busy), 32'd0);
        cx[0] = 16'h0100; cw[0] = 16'h0100;
        run_cmd("post rst", 16'h0001, 16'h0100);

        // Randomized commands with random gaps and accel_en stalls.
        for (int t = 0; t < 40; t++) begin
            n    = $urandom_range(0, 3);
            relu = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                cx[i] = rnd_val();
                cw[i] = rnd_val();
            end
            hdr = {relu, 7'($urandom), 8'(n)};
            exp = model(n, relu);
            send_cmd(hdr, 1'b1);
            wait_done("rand", exp, cyc);
            @(negedge clk);
            chk_eq("rand pulse", 32'(accel_done), 32'd0);
            chk_eq("rand idle", 32'(busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
